// File: rtl/forward_data_unit_if.sv
// Bundle between the pipeline and the forwarding data unit.
// The pipeline side drives the result history, operand and select signals; the unit drives the operands and status.
interface forward_data_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             FREEZE;
  logic             In_Valid;
  logic [4:0]       In_Dest;
  logic [31:0]      In_Data;
  logic             In_Late;
  logic [31:0]      Late_Data;
  logic [31:0]      RF_A;
  logic [31:0]      RF_B;
  logic [1:0]       FwdA_ctl;
  logic [1:0]       FwdB_ctl;
  logic [31:0]      OpA;
  logic [31:0]      OpB;
  logic             Hazard_Stall;
  logic             Fwd_Err;
  logic [CNT_W-1:0] Fwd_Count;

  modport master (
    output FREEZE, In_Valid, In_Dest, In_Data, In_Late, Late_Data,
           RF_A, RF_B, FwdA_ctl, FwdB_ctl,
    input  OpA, OpB, Hazard_Stall, Fwd_Err, Fwd_Count
  );

  modport slave (
    input  FREEZE, In_Valid, In_Dest, In_Data, In_Late, Late_Data,
           RF_A, RF_B, FwdA_ctl, FwdB_ctl,
    output OpA, OpB, Hazard_Stall, Fwd_Err, Fwd_Count
  );
endinterface

// File: rtl/forward_data_unit.sv
// Resolves forward selects against a short result history into registered ALU operands.
// A selected load result that has not yet arrived stalls the unit for one cycle while Late_Data fills it.
module forward_data_unit #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input logic            CLK,
  input logic            RESET,
  forward_data_unit_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        pend;
  } entry_t;

  typedef struct packed {
    logic        hit;
    logic        bad;
    logic [31:0] data;
  } res_t;

  entry_t           h_q [DEPTH];
  entry_t           h_d [DEPTH];
  entry_t           new_e;
  entry_t           h0_filled;
  logic             new_valid;
  logic             stall;
  res_t             res_a;
  res_t             res_b;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_sum;
  logic [1:0]       n_fwd;

  // Code 11 resolves to H[0]: bit0 has priority as the most recent result.
  function automatic res_t resolve(input logic [1:0] ctl, input logic [31:0] rf,
                                   input entry_t h0, input entry_t h1);
    res_t r;
    r = '{hit: 1'b0, bad: 1'b0, data: rf};
    if (ctl[0]) begin
      if (h0.valid) r = '{hit: 1'b1, bad: 1'b0, data: h0.data};
      else          r.bad = 1'b1;
    end else if (ctl[1]) begin
      if (h1.valid) r = '{hit: 1'b1, bad: 1'b0, data: h1.data};
      else          r.bad = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    new_valid = bus.In_Valid && (bus.In_Dest != '0);
    new_e     = '{valid: new_valid,
                  dest:  new_valid ? bus.In_Dest : 5'd0,
                  data:  bus.In_Data,
                  pend:  new_valid && bus.In_Late};

    h0_filled = h_q[0];
    if (h_q[0].pend) begin
      h0_filled.data = bus.Late_Data;
      h0_filled.pend = 1'b0;
    end

    stall = (bus.FwdA_ctl[0] | bus.FwdB_ctl[0]) && h_q[0].valid && h_q[0].pend;

    for (int unsigned i = 0; i < DEPTH; i++) h_d[i] = h_q[i];
    if (stall) begin
      h_d[0] = h0_filled;
    end else begin
      h_d[0] = new_e;
      h_d[1] = h0_filled;
      for (int unsigned i = 2; i < DEPTH; i++) h_d[i] = h_q[i-1];
    end

    res_a = resolve(bus.FwdA_ctl, bus.RF_A, h_q[0], h_q[1]);
    res_b = resolve(bus.FwdB_ctl, bus.RF_B, h_q[0], h_q[1]);
    err_d = err_q | res_a.bad | res_b.bad;

    n_fwd   = {1'b0, res_a.hit} + {1'b0, res_b.hit};
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(n_fwd);
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) h_q[i] <= '0;
      opa_q <= '0;
      opb_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (!bus.FREEZE) begin
      for (int unsigned i = 0; i < DEPTH; i++) h_q[i] <= h_d[i];
      err_q <= err_d;
      if (!stall) begin
        opa_q <= res_a.data;
        opb_q <= res_b.data;
        cnt_q <= cnt_d;
      end
    end
  end

  assign bus.OpA          = opa_q;
  assign bus.OpB          = opb_q;
  assign bus.Hazard_Stall = stall;
  assign bus.Fwd_Err      = err_q;
  assign bus.Fwd_Count    = cnt_q;

endmodule

// File: tb/tb_forward_data_unit.sv
// Directed bench for forward_data_unit: a queue-based history model checked every cycle plus literal spot checks.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_forward_data_unit;

  logic CLK = 1'b0;
  logic RESET;

  forward_data_unit_if #(.CNT_W(16)) bus ();
  forward_data_unit_if #(.CNT_W(2))  bus2 ();

  forward_data_unit #(.DEPTH(3), .CNT_W(16)) u_dut  (.CLK(CLK), .RESET(RESET), .bus(bus));
  forward_data_unit #(.DEPTH(3), .CNT_W(2))  u_dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2));

  assign bus2.FREEZE    = bus.FREEZE;
  assign bus2.In_Valid  = bus.In_Valid;
  assign bus2.In_Dest   = bus.In_Dest;
  assign bus2.In_Data   = bus.In_Data;
  assign bus2.In_Late   = bus.In_Late;
  assign bus2.Late_Data = bus.Late_Data;
  assign bus2.RF_A      = bus.RF_A;
  assign bus2.RF_B      = bus.RF_B;
  assign bus2.FwdA_ctl  = bus.FwdA_ctl;
  assign bus2.FwdB_ctl  = bus.FwdB_ctl;

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    logic [4:0]  dest;
    logic [31:0] data;
    bit          pend;
  } ment_t;

  ment_t       mh[$];
  logic [31:0] m_opa, m_opb;
  bit          m_err;
  int unsigned m_cnt, m_cnt2;

  function automatic void mreset();
    ment_t z;
    z = '{valid: 1'b0, dest: 5'd0, data: 32'd0, pend: 1'b0};
    mh.delete();
    repeat (3) mh.push_back(z);
    m_opa = 0; m_opb = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
  endfunction

  function automatic bit mstall();
    return (bus.FwdA_ctl[0] || bus.FwdB_ctl[0]) && mh[0].valid && mh[0].pend;
  endfunction

  function automatic void mres(input logic [1:0] ctl, input logic [31:0] rf,
                               output logic [31:0] v, output int hit, output bit bad);
    int idx;
    idx = (ctl == 2'b00) ? -1 : (ctl == 2'b10 ? 1 : 0);
    v = rf; hit = 0; bad = 0;
    if (idx >= 0) begin
      if (mh[idx].valid) begin v = mh[idx].data; hit = 1; end
      else bad = 1;
    end
  endfunction

  initial begin
    logic [31:0] va, vb;
    int ha, hb;
    bit ba, bb;
    ment_t ne;
    mreset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) mreset();
      else if (!bus.FREEZE) begin
        mres(bus.FwdA_ctl, bus.RF_A, va, ha, ba);
        mres(bus.FwdB_ctl, bus.RF_B, vb, hb, bb);
        if (mstall()) begin
          mh[0].data = bus.Late_Data;
          mh[0].pend = 0;
          m_err = m_err | ba | bb;
        end else begin
          m_err  = m_err | ba | bb;
          m_opa  = va;
          m_opb  = vb;
          m_cnt  = (m_cnt + ha + hb > 65535) ? 65535 : m_cnt + ha + hb;
          m_cnt2 = (m_cnt2 + ha + hb > 3) ? 3 : m_cnt2 + ha + hb;
          if (mh[0].pend) begin mh[0].data = bus.Late_Data; mh[0].pend = 0; end
          ne.valid = bus.In_Valid && (bus.In_Dest != 0);
          ne.dest  = ne.valid ? bus.In_Dest : 5'd0;
          ne.data  = bus.In_Data;
          ne.pend  = ne.valid && bus.In_Late;
          mh.push_front(ne);
          void'(mh.pop_back());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("model_stall", {31'd0, bus.Hazard_Stall}, {31'd0, mstall()});
        chk("model_opa",   bus.OpA, m_opa);
        chk("model_opb",   bus.OpB, m_opb);
        chk("model_err",   {31'd0, bus.Fwd_Err}, {31'd0, m_err});
        chk("model_cnt",   {16'd0, bus.Fwd_Count}, m_cnt);
        chk("model_cnt2",  {30'd0, bus2.Fwd_Count}, m_cnt2);
        chk("model_opa2",  bus2.OpA, m_opa);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] dest, input logic [31:0] data,
                       input logic late, input logic [31:0] ldata,
                       input logic [1:0] fa, input logic [1:0] fb);
    bus.In_Valid  = v;
    bus.In_Dest   = dest;
    bus.In_Data   = data;
    bus.In_Late   = late;
    bus.Late_Data = ldata;
    bus.FwdA_ctl  = fa;
    bus.FwdB_ctl  = fb;
  endtask

  initial begin
    RESET      = 1'b0;
    bus.FREEZE = 1'b0;
    bus.RF_A   = 32'h1234;
    bus.RF_B   = 32'h5151;
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_opa",   bus.OpA, 32'h0);
    chk("rst_opb",   bus.OpB, 32'h0);
    chk("rst_err",   {31'd0, bus.Fwd_Err}, 32'h0);
    chk("rst_cnt",   {16'd0, bus.Fwd_Count}, 32'h0);
    chk("rst_stall", {31'd0, bus.Hazard_Stall}, 32'h0);

    RESET = 1'b1;
    cyc();
    chk("rf_opa", bus.OpA, 32'h1234);
    chk("rf_opb", bus.OpB, 32'h5151);

    // EXE and MEM forwarding
    drive(1, 5'd3, 32'h55, 0, 0, 2'b00, 2'b00);        cyc();
    drive(1, 5'd5, 32'hAAAA0001, 0, 0, 2'b00, 2'b00);  cyc();
    drive(0, 0, 0, 0, 0, 2'b01, 2'b10);                cyc();
    chk("exe_opa", bus.OpA, 32'hAAAA0001);
    chk("mem_opb", bus.OpB, 32'h55);
    chk("fwd_cnt2", {16'd0, bus.Fwd_Count}, 32'd2);

    // priority on select 11
    drive(1, 5'd8, 32'h22, 0, 0, 2'b00, 2'b00);        cyc();
    drive(1, 5'd9, 32'h11, 0, 0, 2'b00, 2'b00);        cyc();
    drive(0, 0, 0, 0, 0, 2'b11, 2'b10);                cyc();
    chk("prio_opa", bus.OpA, 32'h11);
    chk("prio_opb", bus.OpB, 32'h22);
    chk("cnt_4",    {16'd0, bus.Fwd_Count}, 32'd4);
    chk("sat_cnt",  {30'd0, bus2.Fwd_Count}, 32'd3);

    // load-use stall
    drive(1, 5'd7, 32'hDEAD, 1, 0, 2'b00, 2'b00);      cyc();
    drive(1, 5'd10, 32'h77, 0, 32'hBEEF, 2'b00, 2'b01);
    #1 chk("lu_stall_on", {31'd0, bus.Hazard_Stall}, 32'd1);
    cyc();
    chk("lu_opb_hold",  bus.OpB, 32'h5151);
    chk("lu_cnt_hold",  {16'd0, bus.Fwd_Count}, 32'd4);
    chk("lu_stall_off", {31'd0, bus.Hazard_Stall}, 32'd0);
    cyc();
    chk("lu_opb", bus.OpB, 32'hBEEF);
    chk("lu_cnt", {16'd0, bus.Fwd_Count}, 32'd5);
    drive(0, 0, 0, 0, 0, 2'b01, 2'b10);                cyc();
    chk("noshift_opa", bus.OpA, 32'h77);
    chk("noshift_opb", bus.OpB, 32'hBEEF);

    // late fill without stall, then select from MEM
    drive(1, 5'd12, 32'h0, 1, 0, 2'b00, 2'b00);        cyc();
    drive(0, 0, 0, 0, 32'hCAFE, 2'b00, 2'b00);         cyc();
    drive(0, 0, 0, 0, 0, 2'b00, 2'b10);                cyc();
    chk("fill_opb", bus.OpB, 32'hCAFE);
    chk("fill_cnt", {16'd0, bus.Fwd_Count}, 32'd8);
    chk("err_clear", {31'd0, bus.Fwd_Err}, 32'd0);

    // invalid entry selected
    bus.RF_A = 32'h9;
    bus.RF_B = 32'hB0B;
    drive(0, 0, 0, 0, 0, 2'b01, 2'b00);                cyc();
    chk("inv_opa", bus.OpA, 32'h9);
    chk("inv_err", {31'd0, bus.Fwd_Err}, 32'd1);

    // freeze holds everything
    bus.FREEZE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.RF_A = 32'hF000 + i;
      bus.RF_B = 32'hE000 + i;
      drive(1, 5'd15, 32'h3000 + i, i[0], 32'h4000 + i, 2'(i + 1), 2'b10);
      cyc();
      chk("frz_opa", bus.OpA, 32'h9);
      chk("frz_opb", bus.OpB, 32'hB0B);
      chk("frz_cnt", {16'd0, bus.Fwd_Count}, 32'd8);
    end
    chk("err_sticky", {31'd0, bus.Fwd_Err}, 32'd1);
    bus.FREEZE = 1'b0;
    bus.RF_A   = 32'h9;

    // freeze during a stall: no fill until unfrozen
    drive(1, 5'd4, 32'h0, 1, 0, 2'b00, 2'b00);         cyc();
    bus.FREEZE = 1'b1;
    drive(0, 0, 0, 0, 32'h1111, 2'b01, 2'b00);
    #1 chk("fz_stall_on", {31'd0, bus.Hazard_Stall}, 32'd1);
    cyc();
    chk("fz_stall_hold", {31'd0, bus.Hazard_Stall}, 32'd1);
    bus.FREEZE    = 1'b0;
    bus.Late_Data = 32'h2222;
    cyc();
    chk("fz_stall_off", {31'd0, bus.Hazard_Stall}, 32'd0);
    chk("fz_opa_hold",  bus.OpA, 32'h9);
    cyc();
    chk("fz_opa", bus.OpA, 32'h2222);
    chk("fz_cnt", {16'd0, bus.Fwd_Count}, 32'd9);

    // reset in the middle of a stall
    drive(1, 5'd6, 32'h0, 1, 0, 2'b00, 2'b00);         cyc();
    drive(0, 0, 0, 0, 0, 2'b01, 2'b00);
    #1 chk("rs_stall_on", {31'd0, bus.Hazard_Stall}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("rs_stall_off", {31'd0, bus.Hazard_Stall}, 32'd0);
    chk("rs_err",       {31'd0, bus.Fwd_Err}, 32'd0);
    chk("rs_cnt",       {16'd0, bus.Fwd_Count}, 32'd0);
    bus.FwdA_ctl = 2'b00;
    cyc();
    RESET = 1'b1;
    cyc();
    chk("post_rs_opa", bus.OpA, 32'h9);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
